// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - funct3 encodings for byte/half/word/double accesses (signed and unsigned loads)
//   - FSM state encoding shared by the top level and anything that observes dbg_state_o
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;  // legal only when XLEN == 64
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
//   Request side : req_funct3 + req_lane + req_data -> byte enables, replicated
//                  store data, misalignment flag and illegal-funct3 flag.
//   Response side: rsp_funct3 + rsp_lane + rsp_rdata -> load data shifted down
//                  from its lane and sign/zero extended to XLEN.
// Ports
//   req_funct3   in   3          access size/sign of the incoming instruction
//   req_lane     in   OW         byte offset within the bus word
//   req_data     in   XLEN       store data (LSBs significant)
//   req_be       out  XLEN/8     byte enables
//   req_wdata    out  XLEN       store data replicated across lanes
//   req_misalign out  1          address not naturally aligned for the size
//   req_illegal  out  1          funct3 not supported at this XLEN
//   rsp_funct3   in   3          funct3 latched with the outstanding access
//   rsp_lane     in   OW         byte offset latched with the outstanding access
//   rsp_rdata    in   XLEN       full bus word returned by memory
//   rsp_data     out  XLEN       extended load result
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB  = XLEN / 8,
  localparam int OW  = $clog2(NB)
) (
  input  logic [2:0]      req_funct3,
  input  logic [OW-1:0]   req_lane,
  input  logic [XLEN-1:0] req_data,
  output logic [NB-1:0]   req_be,
  output logic [XLEN-1:0] req_wdata,
  output logic            req_misalign,
  output logic            req_illegal,
  input  logic [2:0]      rsp_funct3,
  input  logic [OW-1:0]   rsp_lane,
  input  logic [XLEN-1:0] rsp_rdata,
  output logic [XLEN-1:0] rsp_data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    req_be       = '0;
    req_wdata    = req_data;
    req_misalign = 1'b0;
    req_illegal  = 1'b0;
    case (req_funct3)
      F3_LB, F3_LBU: begin
        req_be    = NB'(1) << req_lane;
        req_wdata = {NB{req_data[7:0]}};
      end
      F3_LH, F3_LHU: begin
        req_be       = NB'(2'b11) << req_lane;
        req_wdata    = {(NB/2){req_data[15:0]}};
        req_misalign = req_lane[0];
      end
      F3_LW: begin
        req_be       = NB'(4'hF) << req_lane;
        req_wdata    = {(NB/4){req_data[31:0]}};
        req_misalign = (req_lane[1:0] != 2'b00);
      end
      F3_LD: begin
        if (XLEN == 64) begin
          req_be       = '1;
          req_misalign = (req_lane != '0);
        end else begin
          req_illegal = 1'b1;
        end
      end
      default: req_illegal = 1'b1;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend from the access size.
  always_comb begin
    shifted = rsp_rdata >> {rsp_lane, 3'b000};
    case (rsp_funct3)
      F3_LB:   rsp_data = XLEN'($signed(shifted[7:0]));
      F3_LH:   rsp_data = XLEN'($signed(shifted[15:0]));
      F3_LW:   rsp_data = XLEN'($signed(shifted[31:0]));
      F3_LBU:  rsp_data = XLEN'(shifted[7:0]);
      F3_LHU:  rsp_data = XLEN'(shifted[15:0]);
      default: rsp_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit between EX and WB.
// Accepts one load or store from the pipeline, checks it for illegal encodings and
// misalignment, issues it on a req/gnt/rvalid bus, stalls the pipeline until it
// completes and retires it with a one-cycle done_o pulse (ok, misaligned or fault).
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   valid_i, MemRead,        instruction in MEM, load/store select,
//   MemWrite, funct3         access size/sign
//   alu_out, dataB           effective byte address, store data
//   stall_o, done_o          pipeline hold, retire pulse
//   mem_result               registered extended load data (0 for store/fault)
//   misalign_o, fault_o      retire flags, valid with done_o
//   bus_req/we/addr/be/wdata request channel; bus_gnt accepts it
//   bus_rvalid, bus_rdata    read response
//   dbg_state_o              current FSM state
// Handshake: bus_req is held high in REQ until bus_gnt is seen on a rising edge;
// a read completes on the first bus_rvalid sampled in WAIT, or together with
// bus_gnt in REQ. bus_rvalid/bus_gnt in any other state are ignored.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   alu_out,
  input  logic [XLEN-1:0]   dataB,
  output logic              stall_o,
  output logic              done_o,
  output logic [XLEN-1:0]   mem_result,
  output logic              misalign_o,
  output logic              fault_o,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN/8-1:0] bus_be,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [XLEN-1:0]   bus_rdata,
  output state_t            dbg_state_o
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [NB-1:0]   be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      f3_q, f3_d;
  logic [OW-1:0]   lane_q, lane_d;
  logic            we_q, we_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            mis_q, mis_d;
  logic            flt_q, flt_d;

  logic            op;
  logic [TW-1:0]   tmo_inc;
  logic            tmo_hit;
  logic [NB-1:0]   req_be;
  logic [XLEN-1:0] req_wdata;
  logic            req_misalign;
  logic            req_illegal;
  logic [XLEN-1:0] load_data;

  lsu_align #(.XLEN(XLEN)) u_align (
    .req_funct3   (funct3),
    .req_lane     (alu_out[OW-1:0]),
    .req_data     (dataB),
    .req_be       (req_be),
    .req_wdata    (req_wdata),
    .req_misalign (req_misalign),
    .req_illegal  (req_illegal),
    .rsp_funct3   (f3_q),
    .rsp_lane     (lane_q),
    .rsp_rdata    (bus_rdata),
    .rsp_data     (load_data)
  );

  always_comb begin
    // rst is folded in so stall_o drops the moment reset asserts, even with valid_i high.
    op       = rst & valid_i & (MemRead | MemWrite);
    tmo_inc  = tmo_q + TW'(1);
    tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_inc == TW'(TIMEOUT_CYCLES));
    state_d  = state_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    f3_d     = f3_q;
    lane_d   = lane_q;
    we_d     = we_q;
    tmo_d    = tmo_q;
    result_d = result_q;
    mis_d    = mis_q;
    flt_d    = flt_q;
    case (state_q)
      IDLE: begin
        if (op) begin
          tmo_d = '0;
          mis_d = 1'b0;
          flt_d = 1'b0;
          if ((MemRead && MemWrite) || req_illegal) begin
            state_d  = DONE;
            flt_d    = 1'b1;
            result_d = '0;
          end else if (req_misalign) begin
            state_d  = DONE;
            mis_d    = 1'b1;
            result_d = '0;
          end else begin
            state_d = REQ;
            addr_d  = {alu_out[XLEN-1:OW], {OW{1'b0}}};
            be_d    = req_be;
            wdata_d = req_wdata;
            f3_d    = funct3;
            lane_d  = alu_out[OW-1:0];
            we_d    = MemWrite;
          end
        end
      end
      REQ: begin
        tmo_d = tmo_inc;
        // A completing handshake wins over a timeout landing in the same cycle.
        if (bus_gnt && we_q) begin
          state_d  = DONE;
          result_d = '0;
        end else if (bus_gnt && bus_rvalid) begin
          state_d  = DONE;
          result_d = load_data;
        end else if (tmo_hit) begin
          state_d  = DONE;
          flt_d    = 1'b1;
          result_d = '0;
        end else if (bus_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        tmo_d = tmo_inc;
        if (bus_rvalid) begin
          state_d  = DONE;
          result_d = load_data;
        end else if (tmo_hit) begin
          state_d  = DONE;
          flt_d    = 1'b1;
          result_d = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      f3_q     <= '0;
      lane_q   <= '0;
      we_q     <= 1'b0;
      tmo_q    <= '0;
      result_q <= '0;
      mis_q    <= 1'b0;
      flt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      f3_q     <= f3_d;
      lane_q   <= lane_d;
      we_q     <= we_d;
      tmo_q    <= tmo_d;
      result_q <= result_d;
      mis_q    <= mis_d;
      flt_q    <= flt_d;
    end
  end

  assign stall_o     = (state_q == REQ) || (state_q == WAIT) || ((state_q == IDLE) && op);
  assign done_o      = (state_q == DONE);
  assign misalign_o  = done_o & mis_q;
  assign fault_o     = done_o & flt_q;
  assign mem_result  = result_q;
  assign bus_req     = (state_q == REQ);
  assign bus_we      = we_q;
  assign bus_addr    = addr_q;
  assign bus_be      = be_q;
  assign bus_wdata   = wdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu (XLEN=32, TIMEOUT_CYCLES=6).
// Table of single-access vectors with a small bus responder, then hand-written
// sequences for idle behaviour, bus timeout, reset mid-access and result hold.
module tb_mem_stage_lsu;
  import lsu_pkg::*;

  localparam int TMO = 6;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] alu_out;
  logic [31:0] dataB;
  logic        stall_o;
  logic        done_o;
  logic [31:0] mem_result;
  logic        misalign_o;
  logic        fault_o;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  state_t      dbg_state_o;

  int total;
  int bad;

  mem_stage_lsu #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .funct3      (funct3),
    .alu_out     (alu_out),
    .dataB       (dataB),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .mem_result  (mem_result),
    .misalign_o  (misalign_o),
    .fault_o     (fault_o),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_gnt     (bus_gnt),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- vectors ----------------
  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] datab;
    int          gnt_dly;   // REQ cycles with gnt low before gnt
    int          rv_dly;    // 0: rvalid with gnt; k: rvalid in k-th WAIT cycle
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_result;
    logic        exp_mis;
    logic        exp_flt;
    int          exp_stall;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[14];

  // ---------------- scoreboard helper ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- driver + bus responder ----------------
  task automatic run_vec(input vec_t v);
    int  req_cyc;
    int  wait_cyc;
    int  stalls;
    bit  granted;
    bit  done_seen;
    bit  req_seen;
    req_cyc = 0; wait_cyc = 0; stalls = 0;
    granted = 0; done_seen = 0; req_seen = 0;
    @(posedge clk); #1;
    valid_i  = 1'b1;
    MemRead  = v.rd;
    MemWrite = v.wr;
    funct3   = v.f3;
    alu_out  = v.addr;
    dataB    = v.datab;
    bus_gnt  = 1'b0;
    bus_rvalid = 1'b0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      @(negedge clk);
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = 32'hA5A5_A5A5;
      if (done_o) begin
        done_seen = 1;
        chk({v.name, " stall_in_done"}, stall_o, 1'b0);
        chk({v.name, " result"}, mem_result, v.exp_result);
        chk({v.name, " misalign"}, misalign_o, v.exp_mis);
        chk({v.name, " fault"}, fault_o, v.exp_flt);
        chk({v.name, " req_seen"}, req_seen, v.exp_req);
        chk({v.name, " stall_cycles"}, stalls, v.exp_stall);
        valid_i  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
      end else begin
        if (stall_o) stalls++;
        if (bus_req) begin
          if (!req_seen) begin
            chk({v.name, " bus_addr"}, bus_addr, v.exp_addr);
            chk({v.name, " bus_be"}, bus_be, v.exp_be);
            chk({v.name, " bus_we"}, bus_we, v.wr);
            if (v.wr) chk({v.name, " bus_wdata"}, bus_wdata, v.exp_wdata);
          end
          req_seen = 1;
          req_cyc++;
          if (req_cyc > v.gnt_dly) begin
            bus_gnt = 1'b1;
            granted = 1;
            if (!v.wr && v.rv_dly == 0) begin
              bus_rvalid = 1'b1;
              bus_rdata  = v.rdata;
            end
          end
        end else if (granted && !v.wr) begin
          wait_cyc++;
          if (wait_cyc == v.rv_dly) begin
            bus_rvalid = 1'b1;
            bus_rdata  = v.rdata;
          end
        end
      end
    end
    if (!done_seen) chk({v.name, " done_within_budget"}, 1'b0, 1'b1);
  endtask

  // ---------------- test ----------------
  initial begin
    int reqs;
    int stalls;
    bit done_seen;
    total = 0;
    bad   = 0;

    //            name          rd   wr   f3      addr          datab         gd rv rdata         req  eaddr         ebe      eresult       mis  flt  st ewdata
    vecs[0]  = '{"sw",          1'b0,1'b1,3'b010,32'h0000_0100,32'hDEAD_BEEF,0, 0, 32'h0,        1'b1,32'h0000_0100,4'b1111,32'h0,        1'b0,1'b0,2, 32'hDEAD_BEEF};
    vecs[1]  = '{"lb_neg",      1'b1,1'b0,3'b000,32'h0000_0103,32'h0,        0, 3, 32'h80FF_0000,1'b1,32'h0000_0100,4'b1000,32'hFFFF_FF80,1'b0,1'b0,5, 32'h0};
    vecs[2]  = '{"lhu",         1'b1,1'b0,3'b101,32'h0000_0102,32'h0,        0, 1, 32'h8001_1234,1'b1,32'h0000_0100,4'b1100,32'h0000_8001,1'b0,1'b0,3, 32'h0};
    vecs[3]  = '{"sb",          1'b0,1'b1,3'b000,32'h0000_0101,32'h0000_005A,2, 0, 32'h0,        1'b1,32'h0000_0100,4'b0010,32'h0,        1'b0,1'b0,4, 32'h5A5A_5A5A};
    vecs[4]  = '{"lw_mis",      1'b1,1'b0,3'b010,32'h0000_0102,32'h0,        0, 0, 32'h0,        1'b0,32'h0,        4'b0000,32'h0,        1'b1,1'b0,1, 32'h0};
    vecs[5]  = '{"lh_neg",      1'b1,1'b0,3'b001,32'h0000_00FE,32'h0,        0, 0, 32'hFFFE_1234,1'b1,32'h0000_00FC,4'b1100,32'hFFFF_FFFE,1'b0,1'b0,2, 32'h0};
    vecs[6]  = '{"lb_pos",      1'b1,1'b0,3'b000,32'h0000_0201,32'h0,        1, 0, 32'h0000_7F00,1'b1,32'h0000_0200,4'b0010,32'h0000_007F,1'b0,1'b0,3, 32'h0};
    vecs[7]  = '{"lbu",         1'b1,1'b0,3'b100,32'h0000_0203,32'h0,        0, 2, 32'h9A00_0000,1'b1,32'h0000_0200,4'b1000,32'h0000_009A,1'b0,1'b0,4, 32'h0};
    vecs[8]  = '{"sh",          1'b0,1'b1,3'b001,32'h0000_0106,32'h0000_ABCD,1, 0, 32'h0,        1'b1,32'h0000_0104,4'b1100,32'h0,        1'b0,1'b0,3, 32'hABCD_ABCD};
    vecs[9]  = '{"lw",          1'b1,1'b0,3'b010,32'h0000_010C,32'h0,        0, 1, 32'h1234_5678,1'b1,32'h0000_010C,4'b1111,32'h1234_5678,1'b0,1'b0,3, 32'h0};
    vecs[10] = '{"illegal_f3",  1'b1,1'b0,3'b011,32'h0000_0000,32'h0,        0, 0, 32'h0,        1'b0,32'h0,        4'b0000,32'h0,        1'b0,1'b1,1, 32'h0};
    vecs[11] = '{"rd_and_wr",   1'b1,1'b1,3'b010,32'h0000_0100,32'h0,        0, 0, 32'h0,        1'b0,32'h0,        4'b0000,32'h0,        1'b0,1'b1,1, 32'h0};
    vecs[12] = '{"sh_mis",      1'b0,1'b1,3'b001,32'h0000_0103,32'h0000_1111,0, 0, 32'h0,        1'b0,32'h0,        4'b0000,32'h0,        1'b1,1'b0,1, 32'h0};
    vecs[13] = '{"sw_f3_111",   1'b0,1'b1,3'b111,32'h0000_0100,32'h0000_2222,0, 0, 32'h0,        1'b0,32'h0,        4'b0000,32'h0,        1'b0,1'b1,1, 32'h0};

    rst = 1'b0; valid_i = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
    alu_out = '0; dataB = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst stall_o", stall_o, 1'b0);
    chk("rst done_o", done_o, 1'b0);
    chk("rst misalign_o", misalign_o, 1'b0);
    chk("rst fault_o", fault_o, 1'b0);
    chk("rst bus_req", bus_req, 1'b0);
    chk("rst bus_we", bus_we, 1'b0);
    chk("rst bus_addr", bus_addr, 32'h0);
    chk("rst bus_be", bus_be, 4'h0);
    chk("rst bus_wdata", bus_wdata, 32'h0);
    chk("rst mem_result", mem_result, 32'h0);
    chk("rst state", dbg_state_o, IDLE);
    rst = 1'b1;

    // valid_i low: nothing happens even with MemRead set
    @(posedge clk); #1;
    MemRead = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("novalid stall_o", stall_o, 1'b0);
      chk("novalid bus_req", bus_req, 1'b0);
      chk("novalid done_o", done_o, 1'b0);
    end
    MemRead = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // bus timeout: gnt never arrives
    @(posedge clk); #1;
    valid_i = 1'b1; MemRead = 1'b1; funct3 = F3_LW; alu_out = 32'h0000_0300;
    reqs = 0; stalls = 0; done_seen = 0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      @(negedge clk);
      if (done_o) done_seen = 1;
      else begin
        if (stall_o) stalls++;
        if (bus_req) reqs++;
      end
    end
    chk("tmo done_seen", done_seen, 1'b1);
    chk("tmo req_cycles", reqs, TMO);
    chk("tmo stall_cycles", stalls, TMO + 1);
    chk("tmo fault", fault_o, 1'b1);
    chk("tmo misalign", misalign_o, 1'b0);
    chk("tmo bus_req_dropped", bus_req, 1'b0);
    chk("tmo result", mem_result, 32'h0);
    // late response after the fault must be ignored
    valid_i = 1'b0; MemRead = 1'b0;
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("tmo late done_o", done_o, 1'b0);
    chk("tmo late bus_req", bus_req, 1'b0);
    chk("tmo late result", mem_result, 32'h0);
    chk("tmo late state", dbg_state_o, IDLE);
    bus_gnt = 1'b0; bus_rvalid = 1'b0;

    // reset asserted while waiting for read data
    @(posedge clk); #1;
    valid_i = 1'b1; MemRead = 1'b1; funct3 = F3_LW; alu_out = 32'h0000_0400;
    done_seen = 0;
    for (int c = 0; c < 10 && !done_seen; c++) begin
      @(negedge clk);
      bus_gnt = 1'b0;
      if (bus_req) begin
        bus_gnt = 1'b1;
        done_seen = 1;
      end
    end
    chk("rstwait req_reached", done_seen, 1'b1);
    @(negedge clk);
    bus_gnt = 1'b0;
    chk("rstwait in_wait", dbg_state_o, WAIT);
    chk("rstwait stall_before", stall_o, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rstwait bus_req", bus_req, 1'b0);
    chk("rstwait stall_o", stall_o, 1'b0);
    chk("rstwait state", dbg_state_o, IDLE);
    repeat (2) @(negedge clk);
    valid_i = 1'b0; MemRead = 1'b0;
    rst = 1'b1;
    run_vec('{"lw_after_rst", 1'b1, 1'b0, 3'b010, 32'h0000_0404, 32'h0, 0, 1, 32'hCAFE_F00D,
              1'b1, 32'h0000_0404, 4'b1111, 32'hCAFE_F00D, 1'b0, 1'b0, 3, 32'h0});

    // result holds while idle, rvalid noise ignored
    @(negedge clk);
    bus_rvalid = 1'b1; bus_rdata = 32'h0BAD_0BAD;
    repeat (3) @(negedge clk);
    bus_rvalid = 1'b0;
    chk("hold result", mem_result, 32'hCAFE_F00D);
    chk("hold done_o", done_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
